// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit adder with carry in and carry out.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide unsigned adder that reuses one 4-bit adder, one nibble per clock,
// LSB nibble first, with the carry chained through a register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] a_in,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] b_in,
  input  logic                          carry_in,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum_out,
  output logic                          overflow
);

  localparam int W     = NIBBLE_W * NUM_NIBBLES;
  localparam int IDX_W = $clog2(NUM_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  sa_state_t           state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic [W-1:0]        a_reg, b_reg, work_reg;
  logic                carry_reg;
  logic                accept;
  logic                last_nibble;
  logic [NIBBLE_W-1:0] a_nib, b_nib, add_sum;
  logic                add_cout;
  logic [W-1:0]        work_merged;

  assign a_nib       = a_reg[NIBBLE_W*idx_reg +: NIBBLE_W];
  assign b_nib       = b_reg[NIBBLE_W*idx_reg +: NIBBLE_W];
  assign last_nibble = (idx_reg == LAST_IDX);

  adder_4bit u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Working sum with the current nibble written back; also feeds sum_out on the last nibble.
  always_comb begin
    work_merged = work_reg;
    work_merged[NIBBLE_W*idx_reg +: NIBBLE_W] = add_sum;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_nibble) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ADD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      sum_out   <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      idx_reg   <= '0;
      a_reg     <= a_in;
      b_reg     <= b_in;
      work_reg  <= '0;
      carry_reg <= carry_in;
    end else if (state_reg == ADD) begin
      work_reg  <= work_merged;
      carry_reg <= add_cout;
      if (last_nibble) begin
        sum_out  <= work_merged;
        overflow <= add_cout;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign busy = (state_reg == ADD);
  assign done = (state_reg == DONE);

endmodule
